// File: rtl/regfile_psr.sv
// Register file with two combinational read ports, one write port and a masked processor status register.
// Optional write-through forwarding on the read ports when REGFILE_BYPASS_EN is defined.
module regfile_psr #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flag_auto,
  input  logic [7:0]        flag_wr_mask,
  input  logic [7:0]        flag_in,
  output logic [7:0]        psr,
  output logic              carry,
  output logic [7:0]        wr_count
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned PSR_W    = 8;
  localparam int unsigned CNT_W    = 8;
  // Implemented flag bits: N, Z, F, L, C; bits 1, 3, 4 are reserved and stay zero.
  localparam logic [PSR_W-1:0] PSR_VALID = 8'hE5;
  localparam int unsigned Z_BIT = 6;
  localparam int unsigned N_BIT = 7;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [PSR_W-1:0]  psr_d;
  logic              auto_upd;

  // Register array storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Write-through forwarding, independently per port.
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    if (wr_en && (raddr_a == waddr)) rdata_a = wdata;
    if (wr_en && (raddr_b == waddr)) rdata_b = wdata;
  end
`else
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
  end
`endif

  // Next PSR: auto Z/N derivation first, explicit mask overrides it.
  always_comb begin
    auto_upd = wr_en & flag_auto;
    psr_d    = psr;
    if (auto_upd) begin
      psr_d[Z_BIT] = (wdata == '0);
      psr_d[N_BIT] = wdata[DATA_W-1];
    end
    psr_d = (psr_d & ~flag_wr_mask) | (flag_in & flag_wr_mask);
    psr_d = psr_d & PSR_VALID;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psr <= '0;
    end else begin
      psr <= psr_d;
    end
  end

  assign carry = psr[0];

  // Saturating write counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count <= '0;
    end else if (wr_en && (wr_count != {CNT_W{1'b1}})) begin
      wr_count <= wr_count + CNT_W'(1);
    end
  end

endmodule
